mem_arbiter: RTL

Two-port to one-port memory arbiter for the pipelined xg-riscv core when it uses a unified single-port synchronous RAM instead of separate instruction and data memories. It sits between the fetch stage (I-port, driven by pcF) and the memory stage (D-port: addr, writedata, byte-enable amp, memwrite), and drives the shared RAM. It grants one port per cycle, routes the 1-cycle-latency read data back to its owner, and produces stall signals for the hazard logic. It also counts conflict cycles.

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch I-port, memory-stage D-port) to one-port
// arbiter for a unified single-port synchronous RAM with 1-cycle read latency.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   ireq/iaddr          fetch request and address (held until igrant)
//   igrant/istall       combinational fetch grant / stall
//   ivalid/irdata       fetch response one cycle after igrant; irdata holds
//                       the last returned word while ivalid=0
//   dreq/dwe/daddr/dwdata/damp
//                       load/store request, held until dgrant
//   dgrant/dstall       combinational data grant / stall
//   dvalid/drdata       load response one cycle after a load grant
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata
//                       shared RAM interface
//   conflict_cnt        cycles with ireq and dreq both high (wraps)
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              igrant,
  output logic              ivalid,
  output logic [DATA_W-1:0] irdata,
  output logic              istall,
  input  logic              dreq,
  input  logic              dwe,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dwdata,
  input  logic [3:0]        damp,
  output logic              dgrant,
  output logic              dvalid,
  output logic [DATA_W-1:0] drdata,
  output logic              dstall,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       conflict_cnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  // Owner of the read data arriving next cycle
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IRD  = 2'd1;
  localparam logic [1:0] OWN_DRD  = 2'd2;

  logic [1:0]        owner_r;
  logic [1:0]        ownerNext_s;
  logic [3:0]        starveCnt_r;
  logic [DATA_W-1:0] iHold_r;
  logic [DATA_W-1:0] dHold_r;
  logic [31:0]       conflictCnt_r;
  logic              iForce_s;

  // Grant selection: D-port wins unless the I-port has starved long enough
  always_comb begin
    iForce_s = ireq & (starveCnt_r >= STARVE_LIM);
    igrant   = ireq & (~dreq | iForce_s);
    dgrant   = dreq & ~igrant;
    istall   = ireq & ~igrant;
    dstall   = dreq & ~dgrant;
  end

  // RAM drive from the granted port
  always_comb begin
    mem_en    = igrant | dgrant;
    mem_wdata = dwdata;
    if (igrant) begin
      mem_addr = iaddr;
    end else begin
      mem_addr = daddr;
    end
    if (dgrant & dwe) begin
      mem_we = damp;
    end else begin
      mem_we = 4'b0000;
    end
  end

  // Next owner: only reads produce a response; stores leave it NONE
  always_comb begin
    if (igrant) begin
      ownerNext_s = OWN_IRD;
    end else if (dgrant & ~dwe) begin
      ownerNext_s = OWN_DRD;
    end else begin
      ownerNext_s = OWN_NONE;
    end
  end

  // Response routing from the registered owner
  always_comb begin
    case (owner_r)
      OWN_IRD: begin
        ivalid = 1'b1;
        dvalid = 1'b0;
      end
      OWN_DRD: begin
        ivalid = 1'b0;
        dvalid = 1'b1;
      end
      default: begin
        ivalid = 1'b0;
        dvalid = 1'b0;
      end
    endcase
    if (ivalid) begin
      irdata = mem_rdata;
    end else begin
      irdata = iHold_r;
    end
    if (dvalid) begin
      drdata = mem_rdata;
    end else begin
      drdata = dHold_r;
    end
  end

  // State: owner, hold registers, starvation and conflict counters
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r       <= OWN_NONE;
      iHold_r       <= '0;
      dHold_r       <= '0;
      starveCnt_r   <= 4'd0;
      conflictCnt_r <= 32'd0;
    end else begin
      owner_r <= ownerNext_s;
      if (ivalid) begin
        iHold_r <= mem_rdata;
      end
      if (dvalid) begin
        dHold_r <= mem_rdata;
      end
      // Saturating count of consecutive denied fetch cycles
      if (ireq & ~igrant) begin
        if (starveCnt_r != 4'hF) begin
          starveCnt_r <= starveCnt_r + 4'd1;
        end
      end else begin
        starveCnt_r <= 4'd0;
      end
      if (ireq & dreq) begin
        conflictCnt_r <= conflictCnt_r + 32'd1;
      end
    end
  end

  assign conflict_cnt = conflictCnt_r;

endmodule
